// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls and Cows secret generator.
// Digits are 4-bit BCD; an answer packs four digits, most significant first.
package bc_pkg;

  typedef logic [3:0]  digit_t;
  typedef logic [15:0] answer_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam digit_t      DIGIT_MAX  = 4'd9;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/bc_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts every cycle.
// BC_SECRET_GEN_ENTROPY_EN mixes a synchronized entropy bit into the feedback.
module bc_lfsr16
  import bc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entropy_in,
  output logic [15:0] q
);

  logic        w_fb;
  logic [15:0] w_next;

`ifdef BC_SECRET_GEN_ENTROPY_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], entropy_in};
    end
  end

  assign w_fb = (^(q & LFSR_TAPS)) ^ r_sync[1];
`else
  logic w_unused_entropy;
  assign w_unused_entropy = entropy_in;
  assign w_fb = ^(q & LFSR_TAPS);
`endif

  assign w_next = {q[14:0], w_fb};

  // An all-zero state would lock the register; reseed instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else begin
      q <= (w_next == 16'h0000) ? SEED : w_next;
    end
  end

endmodule

// File: rtl/bc_secret_gen.sv
// Bulls and Cows secret generator: four distinct BCD digits by LFSR rejection
// sampling, with a timeout fill of lowest unused digits. Option: BC_SECRET_GEN_ENTROPY_EN.
module bc_secret_gen
  import bc_pkg::*;
#(
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter logic [15:0] DEFAULT_ANSWER = 16'h1234,
  parameter logic [7:0]  MAX_CYCLES     = 8'd255,
  parameter logic        AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        entropy,
  output logic [15:0] answer,
  output logic        answer_valid,
  output logic        busy
);

  state_t      r_state;
  logic        r_first;
  logic [9:0]  r_used;
  logic [2:0]  r_cnt;
  logic [7:0]  r_timer;
  digit_t      r_slot [NUM_DIGITS];
  answer_t     r_answer;
  logic        r_valid;
  logic        r_busy;

  logic [15:0] w_lfsr;
  digit_t      w_cand;
  logic        w_cand_ok;
  digit_t      w_slot_nxt [NUM_DIGITS];
  logic [9:0]  w_used_nxt;
  logic [2:0]  w_cnt_nxt;

  bc_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .entropy_in (entropy),
    .q          (w_lfsr)
  );

  assign w_cand    = w_lfsr[3:0];
  assign w_cand_ok = (w_cand <= DIGIT_MAX) && !r_used[w_cand];

  // Timeout cycle ignores the candidate and fills every open slot at once.
  always_comb begin
    w_slot_nxt = r_slot;
    w_used_nxt = r_used;
    w_cnt_nxt  = r_cnt;
    if (r_timer == MAX_CYCLES) begin
      for (int d = 0; d < 10; d++) begin
        if (!w_used_nxt[d] && (w_cnt_nxt < 3'(NUM_DIGITS))) begin
          w_slot_nxt[w_cnt_nxt[1:0]] = 4'(d);
          w_used_nxt[d]              = 1'b1;
          w_cnt_nxt                  = w_cnt_nxt + 3'd1;
        end
      end
    end else if (w_cand_ok) begin
      w_slot_nxt[r_cnt[1:0]] = w_cand;
      w_used_nxt[w_cand]     = 1'b1;
      w_cnt_nxt              = r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_first  <= AUTO_START;
      r_used   <= 10'b0;
      r_cnt    <= 3'd0;
      r_timer  <= 8'd0;
      r_slot   <= '{default: 4'd0};
      r_answer <= DEFAULT_ANSWER;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        IDLE, READY: begin
          if (new_game || r_first) begin
            r_state <= GEN;
            r_used  <= 10'b0;
            r_cnt   <= 3'd0;
            r_timer <= 8'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        GEN: begin
          r_slot  <= w_slot_nxt;
          r_used  <= w_used_nxt;
          r_cnt   <= w_cnt_nxt;
          r_timer <= r_timer + 8'd1;
          if (w_cnt_nxt == 3'(NUM_DIGITS)) begin
            r_state  <= READY;
            r_answer <= {w_slot_nxt[0], w_slot_nxt[1], w_slot_nxt[2], w_slot_nxt[3]};
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign answer       = r_answer;
  assign answer_valid = r_valid;
  assign busy         = r_busy;

endmodule
